amm_transmit_block: RTL and testbench

Avalon-MM master front end of the memory checker. Accepts one test command at a time and issues either a write burst or a read burst to the memory under test. Write data and byteenables are generated from a fixed or pseudo-random byte pattern. For every accepted read burst it sends a compare packet to `compare_block`, which checks the returned `readdata` against the same pattern.

---
 rtl/memcheck_pkg.sv | 36 +++
 rtl/amm_data_gen.sv | 46 ++++
 rtl/amm_transmit_block.sv | 103 ++++++++++
 tb/tb_amm_transmit_block.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/memcheck_pkg.sv
// memcheck_pkg: shared widths, compare packet, FSM states and pattern/byteenable helpers
package memcheck_pkg;
   localparam int AMM_DATA_W    = 128;
   localparam int AMM_ADDR_W    = 12;
   localparam int AMM_BURST_W   = 11;
   localparam int BYTE_PER_WORD = AMM_DATA_W / 8;
   localparam int BYTE_ADDR_W   = $clog2(BYTE_PER_WORD);
   localparam int ADDR_W        = AMM_ADDR_W - BYTE_ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0]      word_address;
      logic [AMM_BURST_W-1:0] word_burstcount;
      logic [BYTE_ADDR_W-1:0] start_offset;
      logic [BYTE_ADDR_W-1:0] end_offset;
      logic [7:0]             data_ptrn;
      logic                   data_rnd;
   } compare_pkt_struct;

   typedef enum logic [1:0] {IDLE, WRITE, READ} tx_state_e;

   // One step of the byte pattern sequence; compare_block must use the same function.
   function automatic logic [7:0] lfsr_step(input logic [7:0] p);
      return {p[6:0], p[6] ^ p[1] ^ p[0]};
   endfunction

   // Byte lanes from start_offset upward on the first beat, up to end_offset on the last.
   function automatic logic [BYTE_PER_WORD-1:0] be_mask(input logic first, input logic last,
                                                        input logic [BYTE_ADDR_W-1:0] so,
                                                        input logic [BYTE_ADDR_W-1:0] eo);
      logic [BYTE_PER_WORD-1:0] m;
      m = '0;
      for (int i = 0; i < BYTE_PER_WORD; i++)
         m[i] = (!first || BYTE_ADDR_W'(i) >= so) && (!last || BYTE_ADDR_W'(i) <= eo);
      return m;
   endfunction
endpackage

// File: rtl/amm_data_gen.sv
// amm_data_gen: write pattern register and per-beat byteenable register
//   load_i      capture pattern/rnd/offsets, present first-beat byteenable
//   adv_i       write beat accepted: step pattern (if rnd), present next-beat byteenable
//   last_i      the beat being presented next is the last of the burst
//   writedata_o pattern byte replicated; byteenable_o registered lane mask
module amm_data_gen
   import memcheck_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     load_i,
   input  logic                     adv_i,
   input  logic                     last_i,
   input  logic [7:0]               ptrn_i,
   input  logic                     rnd_i,
   input  logic [BYTE_ADDR_W-1:0]   so_i,
   input  logic [BYTE_ADDR_W-1:0]   eo_i,
   output logic [AMM_DATA_W-1:0]    writedata_o,
   output logic [BYTE_PER_WORD-1:0] byteenable_o
);
   logic [7:0]             ptrn_q;
   logic                   rnd_q;
   logic [BYTE_ADDR_W-1:0] so_q;
   logic [BYTE_ADDR_W-1:0] eo_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ptrn_q       <= '0;
         rnd_q        <= 1'b0;
         so_q         <= '0;
         eo_q         <= '0;
         byteenable_o <= '0;
      end else if (load_i) begin
         ptrn_q       <= ptrn_i;
         rnd_q        <= rnd_i;
         so_q         <= so_i;
         eo_q         <= eo_i;
         byteenable_o <= be_mask(1'b1, last_i, so_i, eo_i);
      end else if (adv_i) begin
         ptrn_q       <= rnd_q ? lfsr_step(ptrn_q) : ptrn_q;
         byteenable_o <= be_mask(1'b0, last_i, so_q, eo_q);
      end
   end

   assign writedata_o = {BYTE_PER_WORD{ptrn_q}};
endmodule

// File: rtl/amm_transmit_block.sv
// amm_transmit_block: Avalon-MM master issuing write/read bursts for the memory checker
//   cmd_valid_i/cmd_ready_o/cmd_write_i/cmd_pkt_i  one command at a time, accepted in IDLE
//   address_o/burstcount_o/write_o/read_o/writedata_o/byteenable_o/waitrequest_i  Avalon-MM
//   cmp_pkt_en_o/cmp_pkt_struct_o  compare packet strobe on read accept
//   busy_o  transaction in progress
module amm_transmit_block
   import memcheck_pkg::*;
#(
   parameter int AMM_DATA_W    = memcheck_pkg::AMM_DATA_W,
   parameter int AMM_ADDR_W    = memcheck_pkg::AMM_ADDR_W,
   parameter int AMM_BURST_W   = memcheck_pkg::AMM_BURST_W,
   parameter int BYTE_PER_WORD = AMM_DATA_W / 8,
   parameter int BYTE_ADDR_W   = $clog2(BYTE_PER_WORD),
   parameter int ADDR_W        = AMM_ADDR_W - BYTE_ADDR_W
)(
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic                     cmd_write_i,
   input  compare_pkt_struct        cmd_pkt_i,
   output logic [AMM_ADDR_W-1:0]    address_o,
   output logic [AMM_BURST_W-1:0]   burstcount_o,
   output logic                     write_o,
   output logic                     read_o,
   output logic [AMM_DATA_W-1:0]    writedata_o,
   output logic [BYTE_PER_WORD-1:0] byteenable_o,
   input  logic                     waitrequest_i,
   output logic                     cmp_pkt_en_o,
   output compare_pkt_struct        cmp_pkt_struct_o,
   output logic                     busy_o
);
   tx_state_e              state;
   logic [AMM_BURST_W-1:0] cnt;
   logic                   start;
   logic                   load;
   logic                   adv;
   logic                   last_next;

   assign cmd_ready_o  = state == IDLE;
   assign busy_o       = !cmd_ready_o;
   // Zero-length commands are accepted but never start a transaction.
   assign start        = cmd_ready_o && cmd_valid_i && cmd_pkt_i.word_burstcount != '0;
   assign load         = start && cmd_write_i;
   assign adv          = write_o && !waitrequest_i;
   assign last_next    = load ? cmd_pkt_i.word_burstcount == AMM_BURST_W'(1) : cnt == AMM_BURST_W'(2);
   // The strobe must mark the exact accept cycle, so it follows waitrequest_i directly.
   assign cmp_pkt_en_o = read_o && !waitrequest_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state            <= IDLE;
         cnt              <= '0;
         address_o        <= '0;
         burstcount_o     <= '0;
         write_o          <= 1'b0;
         read_o           <= 1'b0;
         cmp_pkt_struct_o <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               address_o    <= {cmd_pkt_i.word_address[ADDR_W-1:0], {BYTE_ADDR_W{1'b0}}};
               burstcount_o <= cmd_pkt_i.word_burstcount;
               cnt          <= cmd_pkt_i.word_burstcount;
               if (cmd_write_i) begin
                  write_o <= 1'b1;
                  state   <= WRITE;
               end else begin
                  read_o           <= 1'b1;
                  cmp_pkt_struct_o <= cmd_pkt_i;
                  state            <= READ;
               end
            end
            WRITE: if (!waitrequest_i) begin
               cnt <= cnt - 1'b1;
               if (cnt == AMM_BURST_W'(1)) begin
                  write_o <= 1'b0;
                  state   <= IDLE;
               end
            end
            READ: if (!waitrequest_i) begin
               read_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   amm_data_gen u_data_gen (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .load_i       (load),
      .adv_i        (adv),
      .last_i       (last_next),
      .ptrn_i       (cmd_pkt_i.data_ptrn),
      .rnd_i        (cmd_pkt_i.data_rnd),
      .so_i         (cmd_pkt_i.start_offset),
      .eo_i         (cmd_pkt_i.end_offset),
      .writedata_o  (writedata_o),
      .byteenable_o (byteenable_o)
   );
endmodule

// File: tb/tb_amm_transmit_block.sv
// tb_amm_transmit_block: directed checks of the Avalon-MM transmit block
module tb_amm_transmit_block;
   import memcheck_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_write = 1'b0;
   logic              waitreq = 1'b0;
   compare_pkt_struct cmd_pkt = '0;
   logic              cmd_ready;
   logic [11:0]       address;
   logic [10:0]       burstcount;
   logic              write;
   logic              read;
   logic [127:0]      writedata;
   logic [15:0]       byteenable;
   logic              cmp_en;
   compare_pkt_struct cmp_pkt;
   logic              busy;
   int                errors = 0;
   int                checks = 0;
   compare_pkt_struct p;

   amm_transmit_block dut (
      .clk_i            (clk),
      .rst_n_i          (rst_n),
      .cmd_valid_i      (cmd_valid),
      .cmd_ready_o      (cmd_ready),
      .cmd_write_i      (cmd_write),
      .cmd_pkt_i        (cmd_pkt),
      .address_o        (address),
      .burstcount_o     (burstcount),
      .write_o          (write),
      .read_o           (read),
      .writedata_o      (writedata),
      .byteenable_o     (byteenable),
      .waitrequest_i    (waitreq),
      .cmp_pkt_en_o     (cmp_en),
      .cmp_pkt_struct_o (cmp_pkt),
      .busy_o           (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic wr, input compare_pkt_struct c);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_pkt   = c;
      step();
      cmd_valid = 1'b0;
   endtask

   function automatic compare_pkt_struct mk(input logic [7:0] a, input logic [10:0] b,
                                            input logic [3:0] so, input logic [3:0] eo,
                                            input logic [7:0] ptrn, input logic rnd);
      compare_pkt_struct c;
      c = '{word_address: a, word_burstcount: b, start_offset: so, end_offset: eo,
            data_ptrn: ptrn, data_rnd: rnd};
      return c;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] be_exp [4];
      logic [7:0]  rnd_exp [3];
      be_exp  = '{16'hFFF8, 16'hFFFF, 16'hFFFF, 16'h1FFF};
      rnd_exp = '{8'h01, 8'h03, 8'h06};
      #2;
      chk("rst_ready", cmd_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_outs", {address, burstcount, write, read, cmp_en}, '0);
      chk("rst_data", writedata, '0);
      chk("rst_be", byteenable, '0);
      chk("rst_cmp", cmp_pkt, '0);
      #10 rst_n = 1'b1;
      step();

      // fixed-pattern 4-beat write
      send(1'b1, mk(8'h10, 11'd4, 4'd3, 4'd12, 8'hA5, 1'b0));
      for (int b = 0; b < 4; b++) begin
         chk("wr_fix_write", write, 1'b1);
         chk("wr_fix_busy", busy, 1'b1);
         chk("wr_fix_addr", address, 12'h100);
         chk("wr_fix_bc", burstcount, 11'd4);
         chk("wr_fix_data", writedata, {16{8'hA5}});
         chk("wr_fix_be", byteenable, be_exp[b]);
         step();
      end
      chk("wr_fix_end", write, 1'b0);
      chk("wr_fix_ready", cmd_ready, 1'b1);

      // random pattern with stall on beat 2
      send(1'b1, mk(8'h04, 11'd3, 4'd0, 4'd15, 8'h01, 1'b1));
      chk("wr_rnd_d0", writedata, {16{rnd_exp[0]}});
      step();
      waitreq = 1'b1;
      for (int w = 0; w < 3; w++) begin
         chk("wr_rnd_hold", writedata, {16{rnd_exp[1]}});
         chk("wr_rnd_hold_w", write, 1'b1);
         chk("wr_rnd_hold_be", byteenable, 16'hFFFF);
         if (w < 2) step();
      end
      waitreq = 1'b0;
      step();
      chk("wr_rnd_d2", writedata, {16{rnd_exp[2]}});
      chk("wr_rnd_w2", write, 1'b1);
      step();
      chk("wr_rnd_end", write, 1'b0);
      step();

      // read, no stall
      p = mk(8'h20, 11'd8, 4'd1, 4'd9, 8'h5A, 1'b1);
      send(1'b0, p);
      chk("rd_read", read, 1'b1);
      chk("rd_addr", address, 12'h200);
      chk("rd_bc", burstcount, 11'd8);
      chk("rd_cmp_en", cmp_en, 1'b1);
      chk("rd_cmp_pkt", cmp_pkt, p);
      chk("rd_write", write, 1'b0);
      step();
      chk("rd_end", read, 1'b0);
      chk("rd_cmp_off", cmp_en, 1'b0);
      chk("rd_ready", cmd_ready, 1'b1);

      // read with 3 stall cycles
      p = mk(8'h33, 11'd2, 4'd0, 4'd0, 8'h77, 1'b0);
      waitreq = 1'b1;
      send(1'b0, p);
      for (int w = 0; w < 3; w++) begin
         chk("rdw_read", read, 1'b1);
         chk("rdw_no_strobe", cmp_en, 1'b0);
         if (w < 2) step();
      end
      step();
      waitreq = 1'b0;
      #1;
      chk("rdw_strobe", cmp_en, 1'b1);
      chk("rdw_cmp_pkt", cmp_pkt, p);
      step();
      chk("rdw_end", {read, cmp_en}, 2'b00);

      // single-beat byteenables
      send(1'b1, mk(8'h01, 11'd1, 4'd2, 4'd5, 8'h11, 1'b0));
      chk("sb_be", byteenable, 16'h003C);
      chk("sb_write", write, 1'b1);
      step();
      chk("sb_end", write, 1'b0);
      send(1'b1, mk(8'h02, 11'd1, 4'd6, 4'd5, 8'h22, 1'b0));
      chk("sb_inv_be", byteenable, 16'h0000);
      chk("sb_inv_write", write, 1'b1);
      chk("sb_inv_addr", address, 12'h020);
      step();
      chk("sb_inv_end", write, 1'b0);

      // zero burstcount, write and read
      send(1'b1, mk(8'h03, 11'd0, 4'd0, 4'd15, 8'h33, 1'b0));
      chk("z_wr", {write, read, cmp_en, cmd_ready}, 4'b0001);
      send(1'b0, mk(8'h03, 11'd0, 4'd0, 4'd15, 8'h33, 1'b0));
      chk("z_rd", {write, read, cmp_en, cmd_ready}, 4'b0001);
      step();
      chk("z_rd2", {write, read, cmp_en, cmd_ready}, 4'b0001);

      // asynchronous reset mid-burst
      send(1'b1, mk(8'h10, 11'd4, 4'd0, 4'd15, 8'hC3, 1'b1));
      step();
      chk("mr_beat2", write, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mr_outs", {address, burstcount, write, read, cmp_en}, '0);
      chk("mr_data", writedata, '0);
      chk("mr_be", byteenable, '0);
      chk("mr_ready", {cmd_ready, busy}, 2'b10);
      #2 rst_n = 1'b1;
      step();
      p = mk(8'h44, 11'd5, 4'd2, 4'd3, 8'h99, 1'b0);
      send(1'b0, p);
      chk("mr_after_read", {read, cmp_en}, 2'b11);
      chk("mr_after_addr", address, 12'h440);
      chk("mr_after_pkt", cmp_pkt, p);
      step();
      chk("mr_after_end", {read, cmp_en, cmd_ready}, 3'b001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
